// File: rtl/game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// game_tick_scheduler
//
// Purpose:
//    Turns video frame starts into game timing strobes. Every rising edge of
//    frame_start produces a one-cycle input-sample tick (game_tick[0]) in any
//    state. While a game is running, every period-th frame also produces a
//    one-cycle physics/scroll tick (game_tick[1]). After each LEVEL_TICKS
//    physics ticks the period shrinks by one frame, down to PERIOD_MIN, so
//    the game speeds up. Each new game restores the starting speed.
//
// Parameters:
//    PERIOD_INIT  frames per physics tick at game start (1..15)
//    PERIOD_MIN   fastest period (1..PERIOD_INIT, PERIOD_INIT-PERIOD_MIN <= 7)
//    LEVEL_TICKS  physics ticks per speed step (2..256)
//
// Ports:
//    clk               system clock
//    reset             asynchronous, active-high reset
//    frame_start       frame level from video timing; only its rising edge counts
//    game_start_pulse  one-cycle start request (IDLE/OVER -> RUN)
//    game_over_pulse   one-cycle game-over request (RUN -> OVER)
//    game_tick[0]      input-sample strobe, one cycle after each frame edge
//    game_tick[1]      physics/scroll strobe, one cycle after the input strobe
//                      of a frame that completes the current period
//    running           registered, high while the game is in RUN
//    speed_level       number of speed steps taken in the current game
// -----------------------------------------------------------------------------
module game_tick_scheduler #(
   parameter int PERIOD_INIT = 6,
   parameter int PERIOD_MIN  = 2,
   parameter int LEVEL_TICKS = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_start,
   input  logic       game_start_pulse,
   input  logic       game_over_pulse,
   output logic [1:0] game_tick,
   output logic       running,
   output logic [2:0] speed_level
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_OVER = 2'd2
   } state_t;

   localparam logic [3:0] PERIOD_INIT_V = 4'(PERIOD_INIT);
   localparam logic [3:0] PERIOD_MIN_V  = 4'(PERIOD_MIN);
   localparam logic [7:0] LEVEL_LAST    = 8'(LEVEL_TICKS - 1);

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   state_t      state_q,     state_d;
   logic        fs_q,        fs_d;
   logic        armed_q,     armed_d;
   logic        tick0_q,     tick0_d;
   logic        tick1_q,     tick1_d;
   logic        running_q,   running_d;
   logic [2:0]  speed_q,     speed_d;
   logic [3:0]  frame_cnt_q, frame_cnt_d;
   logic [3:0]  period_q,    period_d;
   logic [7:0]  level_cnt_q, level_cnt_d;

   // Decoded FSM controls
   logic        run_entry;
   logic        in_run;
   logic        stay_run;

   // Datapath helpers
   logic        frame_edge;
   logic        frame_last;
   logic        level_last;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic. In RUN only the game-over pulse is looked at, so a
   // simultaneous start pulse loses.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (game_start_pulse) state_d = S_RUN;
         S_RUN:   if (game_over_pulse)  state_d = S_OVER;
         S_OVER:  if (game_start_pulse) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output decode
   // ---------------------------------------------------------------------------
   always_comb begin
      in_run    = (state_q == S_RUN);
      run_entry = (state_q != S_RUN) && (state_d == S_RUN);
      // A physics tick is only emitted if the game is still running in the
      // cycle the strobe would be visible.
      stay_run  = in_run && (state_d == S_RUN);
      running_d = (state_d == S_RUN);
   end

   // ---------------------------------------------------------------------------
   // Frame edge detection and tick generation
   // ---------------------------------------------------------------------------
   always_comb begin
      fs_d       = frame_start;
      // After reset, frame_start must be seen low once before an edge is
      // accepted, so a level that was already high does not fake a frame.
      armed_d    = armed_q | ~frame_start;
      frame_edge = frame_start & ~fs_q & armed_q;
      tick0_d    = frame_edge;

      frame_last = (frame_cnt_q == (period_q - 4'd1));
      tick1_d    = tick0_q & stay_run & frame_last;
   end

   // ---------------------------------------------------------------------------
   // Frame counter, level counter and period/speed update
   // ---------------------------------------------------------------------------
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      level_cnt_d = level_cnt_q;
      period_d    = period_q;
      speed_d     = speed_q;
      level_last  = (level_cnt_q == LEVEL_LAST);

      if (run_entry) begin
         frame_cnt_d = 4'd0;
         level_cnt_d = 8'd0;
         period_d    = PERIOD_INIT_V;
         speed_d     = 3'd0;
      end else begin
         if (in_run && tick0_q) begin
            frame_cnt_d = frame_last ? 4'd0 : (frame_cnt_q + 4'd1);
         end
         // The shortened period is picked up by the next frame comparison;
         // input and physics ticks never share a cycle, so no ordering issue.
         if (tick1_q) begin
            if (level_last) begin
               level_cnt_d = 8'd0;
               if (period_q > PERIOD_MIN_V) begin
                  period_d = period_q - 4'd1;
                  speed_d  = speed_q + 3'd1;
               end
            end else begin
               level_cnt_d = level_cnt_q + 8'd1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath/control register bank
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fs_q        <= 1'b0;
         armed_q     <= 1'b0;
         tick0_q     <= 1'b0;
         tick1_q     <= 1'b0;
         running_q   <= 1'b0;
         speed_q     <= 3'd0;
         frame_cnt_q <= 4'd0;
         period_q    <= PERIOD_INIT_V;
         level_cnt_q <= 8'd0;
      end else begin
         fs_q        <= fs_d;
         armed_q     <= armed_d;
         tick0_q     <= tick0_d;
         tick1_q     <= tick1_d;
         running_q   <= running_d;
         speed_q     <= speed_d;
         frame_cnt_q <= frame_cnt_d;
         period_q    <= period_d;
         level_cnt_q <= level_cnt_d;
      end
   end

   assign game_tick   = {tick1_q, tick0_q};
   assign running     = running_q;
   assign speed_level = speed_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// -----------------------------------------------------------------------------
// tb_game_tick_scheduler
//
// Directed bench for game_tick_scheduler with default parameters
// (PERIOD_INIT=6, PERIOD_MIN=2, LEVEL_TICKS=64). Each stimulus frame raises
// frame_start for `hold` cycles then drops it for `gap` cycles; per-frame tick
// counts and positions are compared against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_game_tick_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_start;
   logic       game_start_pulse;
   logic       game_over_pulse;
   logic [1:0] game_tick;
   logic       running;
   logic [2:0] speed_level;

   game_tick_scheduler #(
      .PERIOD_INIT (6),
      .PERIOD_MIN  (2),
      .LEVEL_TICKS (64)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .frame_start      (frame_start),
      .game_start_pulse (game_start_pulse),
      .game_over_pulse  (game_over_pulse),
      .game_tick        (game_tick),
      .running          (running),
      .speed_level      (speed_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hold;
      int gap;
      int st_at;     // cycle index whose rising edge samples the start pulse (0 = none)
      int ov_at;     // same for game_over_pulse
      int exp_n0;    // cycles with game_tick[0] high in the frame
      int exp_n1;    // cycles with game_tick[1] high in the frame
      int exp_p1;    // cycle index of game_tick[1] (0 = none)
      int exp_run;   // running at end of frame
      int exp_speed; // speed_level at end of frame
   } vec_t;

   vec_t vecs[$];

   int checks   = 0;
   int failures = 0;
   int tick_total = 0;

   // Results of the most recent frame
   int f_n0, f_n1, f_p0, f_p1, f_ov;

   function automatic vec_t mk(int hold, int gap, int st_at, int ov_at, int n0,
                               int n1, int p1, int run, int speed);
      vec_t v;
      v.hold = hold; v.gap = gap; v.st_at = st_at; v.ov_at = ov_at;
      v.exp_n0 = n0; v.exp_n1 = n1; v.exp_p1 = p1;
      v.exp_run = run; v.exp_speed = speed;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic observe(input int k);
      if (game_tick[0]) begin
         f_n0++;
         if (f_p0 == 0) f_p0 = k;
      end
      if (game_tick[1]) begin
         f_n1++;
         if (f_p1 == 0) f_p1 = k;
      end
      if (game_tick == 2'b11) f_ov++;
   endtask

   task automatic frame(input int hold, input int gap, input int st_at, input int ov_at);
      f_n0 = 0; f_n1 = 0; f_p0 = 0; f_p1 = 0; f_ov = 0;
      frame_start = 1'b1;
      for (int k = 1; k <= hold + gap; k++) begin
         game_start_pulse = (st_at == k);
         game_over_pulse  = (ov_at == k);
         step();
         game_start_pulse = 1'b0;
         game_over_pulse  = 1'b0;
         if (k == hold) frame_start = 1'b0;
         observe(k);
      end
      tick_total += f_n1;
   endtask

   task automatic apply_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         frame(vecs[i].hold, vecs[i].gap, vecs[i].st_at, vecs[i].ov_at);
         chk($sformatf("v%0d_n0", i), f_n0, vecs[i].exp_n0);
         chk($sformatf("v%0d_p0", i), f_p0, 1);
         chk($sformatf("v%0d_n1", i), f_n1, vecs[i].exp_n1);
         chk($sformatf("v%0d_p1", i), f_p1, vecs[i].exp_p1);
         chk($sformatf("v%0d_overlap", i), f_ov, 0);
         chk($sformatf("v%0d_running", i), int'(running), vecs[i].exp_run);
         chk($sformatf("v%0d_speed", i), int'(speed_level), vecs[i].exp_speed);
      end
   endtask

   // Run plain frames until the physics tick total reaches target (bounded).
   task automatic run_until(input int target);
      int nfr;
      nfr = 0;
      while (tick_total < target && nfr < 2000) begin
         frame(2, 2, 0, 0);
         nfr++;
      end
      chk($sformatf("ticks_reach_%0d", target), tick_total, target);
   endtask

   // Count frames up to and including the next physics tick (bounded).
   task automatic measure_period(input string name, input int exp);
      int nf;
      nf = 0;
      do begin
         frame(2, 2, 0, 0);
         nf++;
      end while (f_n1 == 0 && nf < 20);
      chk(name, nf, exp);
   endtask

   int a_start, b_start, b_end;
   int rn0, rn1;

   initial begin
      reset            = 1'b1;
      frame_start      = 1'b0;
      game_start_pulse = 1'b0;
      game_over_pulse  = 1'b0;

      // ---- vector table ----------------------------------------------------
      // A: 10 idle frames with frame_start held 5 cycles
      for (int i = 0; i < 10; i++) vecs.push_back(mk(5, 1, 0, 0, 1, 0, 0, 0, 0));
      // Start in a frame (after its input tick), then 18 running frames
      vecs.push_back(mk(2, 2, 3, 0, 1, 0, 0, 1, 0));
      for (int f = 1; f <= 18; f++) begin
         if (f % 6 == 0) vecs.push_back(mk(2, 2, 0, 0, 1, 1, 2, 1, 0));
         else            vecs.push_back(mk(2, 2, 0, 0, 1, 0, 0, 1, 0));
      end
      a_start = 0;
      b_start = vecs.size();
      // B: game over / restart, entered with period 2, frame_cnt 0, speed 4
      vecs.push_back(mk(2, 2, 0, 0, 1, 0, 0, 1, 4)); // frame_cnt -> 1
      vecs.push_back(mk(2, 2, 0, 2, 1, 0, 0, 0, 4)); // over in scheduling cycle
      vecs.push_back(mk(2, 2, 0, 0, 1, 0, 0, 0, 4)); // OVER: speed held
      vecs.push_back(mk(2, 2, 3, 0, 1, 0, 0, 1, 0)); // restart from OVER
      for (int f = 1; f <= 5; f++) vecs.push_back(mk(2, 2, 0, 0, 1, 0, 0, 1, 0));
      vecs.push_back(mk(2, 2, 0, 0, 1, 1, 2, 1, 0)); // 6th frame -> physics
      vecs.push_back(mk(2, 2, 2, 2, 1, 0, 0, 0, 0)); // start+over together
      vecs.push_back(mk(2, 2, 0, 0, 1, 0, 0, 0, 0)); // stays in OVER
      b_end = vecs.size();

      // ---- reset state -----------------------------------------------------
      step(); step();
      chk("rst_tick", int'(game_tick), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_speed", int'(speed_level), 0);
      reset = 1'b0;
      step(); step();

      // ---- idle ticking, start, default period -----------------------------
      apply_range(a_start, b_start);

      // ---- speed-up --------------------------------------------------------
      run_until(63);
      chk("speed_before_step", int'(speed_level), 0);
      run_until(64);
      chk("speed_after_64", int'(speed_level), 1);
      measure_period("period_after_64", 5);
      run_until(255);
      chk("speed_at_255", int'(speed_level), 3);
      run_until(256);
      chk("speed_at_256", int'(speed_level), 4);
      measure_period("period_after_256", 2);
      run_until(330);
      chk("speed_saturated", int'(speed_level), 4);
      measure_period("period_saturated", 2);

      // ---- game over / restart ---------------------------------------------
      apply_range(b_start, b_end);

      // ---- asynchronous reset with a physics tick pending ------------------
      frame(2, 2, 3, 0);
      chk("pre_rst_running", int'(running), 1);
      for (int f = 1; f <= 5; f++) frame(2, 2, 0, 0);
      chk("pre_rst_no_tick", f_n1, 0);
      frame_start = 1'b1;
      step();                               // input tick cycle, physics scheduled
      chk("pre_rst_tick0", int'(game_tick), 1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_tick", int'(game_tick), 0);
      chk("async_rst_running", int'(running), 0);
      chk("async_rst_speed", int'(speed_level), 0);
      step(); step();
      reset = 1'b0;
      // frame_start still high after release: must not count as an edge
      rn0 = 0; rn1 = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (game_tick[0]) rn0++;
         if (game_tick[1]) rn1++;
      end
      frame_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (game_tick[0]) rn0++;
         if (game_tick[1]) rn1++;
      end
      chk("post_rst_no_tick0", rn0, 0);
      chk("post_rst_no_tick1", rn1, 0);
      frame(2, 2, 0, 0);
      chk("post_rst_first_p0", f_p0, 1);
      chk("post_rst_first_n0", f_n0, 1);
      chk("post_rst_first_n1", f_n1, 0);
      for (int f = 0; f < 6; f++) begin
         frame(2, 2, 0, 0);
         rn1 += f_n1;
      end
      chk("post_rst_idle_n1", rn1, 0);
      chk("post_rst_running", int'(running), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the bench always ends on its own.
   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule
